// File: rtl/score_collector_12_if.sv
// score_collector_12_if: score input stream and packed frame output handshake
interface score_collector_12_if #(
   parameter int DATA_LEN = 18,
   parameter int N        = 12
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_LEN-1:0]   in_data;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [N*DATA_LEN-1:0] out_data;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/score_collector_12.sv
// score_collector_12: gathers 12 signed scores into one packed frame for a 12-way comparator
module score_collector_12 #(
   parameter int DATA_LEN = 18,
   parameter int N        = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   score_collector_12_if.slave bus,
   output logic                frame_err_o,
   output logic [3:0]          count_o
);
   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] FULL = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [3:0]            count_q, count_d;
   logic                  err_q, err_d;
   logic [N*DATA_LEN-1:0] data_q, data_d;
   logic                  acc, last_slot;

   assign acc       = bus.in_valid && (state_q == FILL);
   assign last_slot = (count_q == 4'(N - 1));

   // in_last must coincide exactly with slot 11; any mismatch drops the frame
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = 1'b0;
      data_d  = data_q;
      if (acc) begin
         data_d[count_q*DATA_LEN +: DATA_LEN] = bus.in_data;
         count_d = (bus.in_last || last_slot) ? 4'd0 : count_q + 4'd1;
         err_d   = bus.in_last != last_slot;
         state_d = (bus.in_last && last_slot) ? FULL : FILL;
      end else if (state_q == FULL && bus.out_ready) begin
         state_d = FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         count_q <= 4'd0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   assign bus.in_ready  = (state_q == FILL);
   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = data_q;
   assign frame_err_o   = err_q;
   assign count_o       = count_q;
endmodule

// File: doc/score_collector_12.md
SCORE_COLLECTOR_12 -- requirements
Module: score_collector_12

Interface
- REQ-001: Parameter DATA_LEN, default 18, SHALL set the width of one signed score; it equals the codebase data_len.
- REQ-002: Parameter N, default 12, SHALL set the number of scores per frame and is fixed at 12 for this block.
- REQ-003: The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
  - clk  input  1  rising-edge clock.
  - rst_n  input  1  asynchronous active-low reset.
- REQ-004: in_valid  input  1  SHALL indicate that in_data and in_last carry a score.
- REQ-005: in_ready  output  1  SHALL indicate that the block accepts a score this cycle.
- REQ-006: in_data  input  DATA_LEN  SHALL carry one signed score.
- REQ-007: in_last  input  1  SHALL mark the final score of a frame.
- REQ-008: out_valid  output  1  SHALL indicate that out_data holds a complete frame.
- REQ-009: out_ready  input  1  SHALL indicate that the downstream 12-way comparator consumes the frame.
- REQ-010: out_data  output  12*DATA_LEN  SHALL present the packed frame, with element k at bits [k*DATA_LEN +: DATA_LEN].
- REQ-011: frame_err  output  1  SHALL pulse for one cycle on a framing error.
- REQ-012: count  output  4  SHALL present the number of scores accepted in the current frame (0..11).

Function
- REQ-013: The block SHALL have two states, FILL and FULL.
  - in_ready SHALL be 1 iff the state is FILL.
  - out_valid SHALL be 1 iff the state is FULL.
  - Both are decoded from registered state only.
- REQ-014: An accept SHALL occur on a rising clk edge with in_valid=1 and in_ready=1.
  - in_data is written to slot count.
  - The first accepted score of a frame SHALL land in element 0 (LSBs).
- REQ-015: An accept with count<11 and in_last=0 SHALL increment count by 1.
- REQ-016: An accept with count=11 and in_last=1 SHALL write slot 11, set count to 0 and enter FULL; out_valid SHALL be 1 on the next cycle (1-cycle latency from the last score).
- REQ-017: An accept with count<11 and in_last=1 SHALL:
  - drop the frame;
  - set count to 0;
  - pulse frame_err for exactly one cycle;
  - remain in FILL.
- REQ-018: An accept with count=11 and in_last=0 SHALL:
  - drop the frame;
  - set count to 0;
  - pulse frame_err for exactly one cycle;
  - remain in FILL.
- REQ-019: In FULL, out_data SHALL be held stable and in_data SHALL be ignored regardless of in_valid.
- REQ-020: In FULL with out_ready=1 at a rising edge, the block SHALL return to FILL; in_ready SHALL be 1 on the next cycle (one-cycle bubble, no same-cycle refill).
- REQ-021: In FULL with out_ready=0, the block SHALL stay in FULL indefinitely with out_valid=1 (no timeout).
- REQ-022: out_ready SHALL be ignored in FILL.
- REQ-023: Slots SHALL not be cleared between frames.
  - A new frame overwrites slots 0..11 in order.
  - out_data content while out_valid=0 is undefined to consumers.
- REQ-024: Scores SHALL be stored bit-exact, with no sign extension, saturation or arithmetic.
- REQ-025: in_valid=0 cycles inside a frame SHALL be permitted and SHALL leave count and slots unchanged.

Reset
- REQ-026: When rst_n=0, the block SHALL immediately, independent of clk, set:
  - state to FILL;
  - count to 0;
  - out_valid to 0;
  - out_data to 0;
  - frame_err to 0;
  - in_ready to 1 (decoded from the FILL state).
- REQ-027: Reset asserted mid-frame or in FULL SHALL discard all partial and complete data.
- REQ-028: The first accept after rst_n rises SHALL write element 0.
- REQ-029: All state SHALL update only on rising clk edges while rst_n=1.

Verification
- REQ-030: The bench SHALL cover the following directed scenarios.
  - Scores 0..11 on consecutive cycles with in_last on the 12th, out_ready=1 -> out_valid=1 one cycle after the 12th score; out_data equals {11,10,...,1,0} at 18 bits each; out_valid drops after one cycle; in_ready=1 the following cycle.
  - Same frame with out_ready=0 for 20 cycles -> out_valid stays 1, in_ready stays 0, out_data unchanged while in_data toggles; then out_ready=1 -> FILL next cycle.
  - Scores -5, 7, and -131072 (min signed 18-bit) in slots 0, 5 and 11 with gaps of in_valid=0 -> slots hold the exact bit patterns; count does not advance in the gaps.
  - in_last on the 5th score -> frame_err is 1 for one cycle, count=0, no out_valid; next full 12-score frame is delivered correctly.
  - 12th score without in_last -> frame_err pulses and no out_valid.
  - rst_n pulsed low asynchronously after 6 scores, and again while in FULL -> outputs return to reset values without a clock edge; the next frame starts at element 0.
